// File: rtl/gmem_mem_pkg.sv
// Shared definitions for the gmem AXI4 slave memory.
//   RESP_*    : AXI response codes driven on BRESP/RRESP
//   w_state_t : write engine states
//   r_state_t : read engine states
package gmem_mem_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_SEND} r_state_t;

endpackage

// File: rtl/gmem_ram_sdp.sv
// Simple dual-port RAM: one byte-enabled write port, one registered read port.
// A read and a write to the same word on the same edge returns the old data.
//   i_clk                         : clock
//   i_we / i_waddr / i_wdata / i_wstrb : write port, one strobe bit per byte
//   i_re / i_raddr                : read enable and word index
//   o_rdata                       : read data, updated only when i_re is high
module gmem_ram_sdp #(
    parameter int DEPTH      = 4096,
    parameter int DATA_WIDTH = 512
) (
    input  logic                      i_clk,
    input  logic                      i_we,
    input  logic [$clog2(DEPTH)-1:0]  i_waddr,
    input  logic [DATA_WIDTH-1:0]     i_wdata,
    input  logic [DATA_WIDTH/8-1:0]   i_wstrb,
    input  logic                      i_re,
    input  logic [$clog2(DEPTH)-1:0]  i_raddr,
    output logic [DATA_WIDTH-1:0]     o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int b = 0; b < DATA_WIDTH/8; b++) begin
                if (i_wstrb[b]) r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
            end
        end
        if (i_re) o_rdata <= r_mem[i_raddr];
    end

endmodule

// File: rtl/gmem_axi_slave_mem.sv
// AXI4 slave backed by on-chip RAM for the kernel's 512-bit gmem port.
// Independent read and write engines, one outstanding INCR burst each,
// aligned-beat model (addr[5:0] and AxSIZE ignored), index wraps mod DEPTH.
// Optional macro GMEM_DECERR_EN: beats at or above DEPTH*64 bytes are
// suppressed on write (BRESP=DECERR) and return zero data with RRESP=DECERR.
// Ports: ap_clk/ap_rst (sync, active high), AXI AW/W/B and AR/R channels.
module gmem_axi_slave_mem
    import gmem_mem_pkg::*;
#(
    parameter int ID_WIDTH   = 1,
    parameter int ADDR_WIDTH = 42,
    parameter int DATA_WIDTH = 512,
    parameter int DEPTH      = 4096
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst,
    input  logic                    s_axi_AWVALID,
    output logic                    s_axi_AWREADY,
    input  logic [ADDR_WIDTH-1:0]   s_axi_AWADDR,
    input  logic [ID_WIDTH-1:0]     s_axi_AWID,
    input  logic [7:0]              s_axi_AWLEN,
    input  logic [2:0]              s_axi_AWSIZE,
    input  logic                    s_axi_WVALID,
    output logic                    s_axi_WREADY,
    input  logic [DATA_WIDTH-1:0]   s_axi_WDATA,
    input  logic [DATA_WIDTH/8-1:0] s_axi_WSTRB,
    input  logic                    s_axi_WLAST,
    output logic                    s_axi_BVALID,
    input  logic                    s_axi_BREADY,
    output logic [1:0]              s_axi_BRESP,
    output logic [ID_WIDTH-1:0]     s_axi_BID,
    input  logic                    s_axi_ARVALID,
    output logic                    s_axi_ARREADY,
    input  logic [ADDR_WIDTH-1:0]   s_axi_ARADDR,
    input  logic [ID_WIDTH-1:0]     s_axi_ARID,
    input  logic [7:0]              s_axi_ARLEN,
    input  logic [2:0]              s_axi_ARSIZE,
    output logic                    s_axi_RVALID,
    input  logic                    s_axi_RREADY,
    output logic [DATA_WIDTH-1:0]   s_axi_RDATA,
    output logic                    s_axi_RLAST,
    output logic [ID_WIDTH-1:0]     s_axi_RID,
    output logic [1:0]              s_axi_RRESP
);

    localparam int IW = $clog2(DEPTH);
    localparam int WA = ADDR_WIDTH - 6;   // word-address width

    w_state_t              r_w_state, w_w_next;
    logic [ID_WIDTH-1:0]   r_w_id;
    logic [WA-1:0]         r_w_addr;
    logic [7:0]            r_w_cnt;
    logic                  r_w_err, r_w_dec;
    r_state_t              r_r_state, w_r_next;
    logic [ID_WIDTH-1:0]   r_r_id;
    logic [WA-1:0]         r_r_addr;
    logic [7:0]            r_r_cnt;
    logic                  w_ram_we, w_ram_re;
    logic [DATA_WIDTH-1:0] w_ram_rdata;
    logic                  w_w_oor, w_r_oor, w_w_dec_beat, w_r_dec_beat;

    // Full word address is tracked so a burst walking past the top is detectable.
    assign w_w_oor = |r_w_addr[WA-1:IW];
    assign w_r_oor = |r_r_addr[WA-1:IW];

`ifdef GMEM_DECERR_EN
    assign w_w_dec_beat = w_w_oor;
    assign w_r_dec_beat = w_r_oor;
`else
    assign w_w_dec_beat = 1'b0;
    assign w_r_dec_beat = 1'b0;
    logic w_unused_oor;
    assign w_unused_oor = ^{w_w_oor, w_r_oor};
`endif

    logic w_unused_ok;
    assign w_unused_ok = ^{s_axi_AWADDR[5:0], s_axi_ARADDR[5:0], s_axi_AWSIZE, s_axi_ARSIZE};

    assign s_axi_BID = r_w_id;
    assign s_axi_RID = r_r_id;

    // Write engine
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_w_state <= W_IDLE;
            r_w_id    <= '0;
            r_w_addr  <= '0;
            r_w_cnt   <= '0;
            r_w_err   <= 1'b0;
            r_w_dec   <= 1'b0;
        end else begin
            r_w_state <= w_w_next;
            case (r_w_state)
                W_IDLE: if (s_axi_AWVALID) begin
                    r_w_id   <= s_axi_AWID;
                    r_w_addr <= s_axi_AWADDR[ADDR_WIDTH-1:6];
                    r_w_cnt  <= s_axi_AWLEN;
                    r_w_err  <= 1'b0;
                    r_w_dec  <= 1'b0;
                end
                W_DATA: if (s_axi_WVALID) begin
                    if (s_axi_WLAST != (r_w_cnt == 8'd0)) r_w_err <= 1'b1;
                    if (w_w_dec_beat) r_w_dec <= 1'b1;
                    r_w_addr <= r_w_addr + WA'(1);
                    r_w_cnt  <= r_w_cnt - 8'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_w_next      = r_w_state;
        s_axi_AWREADY = 1'b0;
        s_axi_WREADY  = 1'b0;
        s_axi_BVALID  = 1'b0;
        s_axi_BRESP   = RESP_OKAY;
        w_ram_we      = 1'b0;
        case (r_w_state)
            W_IDLE: begin
                s_axi_AWREADY = 1'b1;
                if (s_axi_AWVALID) w_w_next = W_DATA;
            end
            W_DATA: begin
                s_axi_WREADY = 1'b1;
                if (s_axi_WVALID) begin
                    w_ram_we = !w_w_dec_beat;
                    // Counter, not WLAST, decides where the burst ends.
                    if (r_w_cnt == 8'd0) w_w_next = W_RESP;
                end
            end
            W_RESP: begin
                s_axi_BVALID = 1'b1;
                s_axi_BRESP  = r_w_dec ? RESP_DECERR : (r_w_err ? RESP_SLVERR : RESP_OKAY);
                if (s_axi_BREADY) w_w_next = W_IDLE;
            end
            default: w_w_next = W_IDLE;
        endcase
    end

    // Read engine
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_r_state <= R_IDLE;
            r_r_id    <= '0;
            r_r_addr  <= '0;
            r_r_cnt   <= '0;
        end else begin
            r_r_state <= w_r_next;
            case (r_r_state)
                R_IDLE: if (s_axi_ARVALID) begin
                    r_r_id   <= s_axi_ARID;
                    r_r_addr <= s_axi_ARADDR[ADDR_WIDTH-1:6];
                    r_r_cnt  <= s_axi_ARLEN;
                end
                R_SEND: if (s_axi_RREADY && r_r_cnt != 8'd0) begin
                    r_r_addr <= r_r_addr + WA'(1);
                    r_r_cnt  <= r_r_cnt - 8'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_r_next      = r_r_state;
        s_axi_ARREADY = 1'b0;
        s_axi_RVALID  = 1'b0;
        s_axi_RLAST   = 1'b0;
        s_axi_RRESP   = RESP_OKAY;
        s_axi_RDATA   = '0;
        w_ram_re      = 1'b0;
        case (r_r_state)
            R_IDLE: begin
                s_axi_ARREADY = 1'b1;
                if (s_axi_ARVALID) w_r_next = R_FETCH;
            end
            R_FETCH: begin
                w_ram_re = 1'b1;
                w_r_next = R_SEND;
            end
            R_SEND: begin
                // RAM output only changes in R_FETCH, so the beat stays stable under stall.
                s_axi_RVALID = 1'b1;
                s_axi_RLAST  = (r_r_cnt == 8'd0);
                if (w_r_dec_beat) s_axi_RRESP = RESP_DECERR;
                else              s_axi_RDATA = w_ram_rdata;
                if (s_axi_RREADY) w_r_next = (r_r_cnt == 8'd0) ? R_IDLE : R_FETCH;
            end
            default: w_r_next = R_IDLE;
        endcase
    end

    gmem_ram_sdp #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .i_clk   (ap_clk),
        .i_we    (w_ram_we),
        .i_waddr (r_w_addr[IW-1:0]),
        .i_wdata (s_axi_WDATA),
        .i_wstrb (s_axi_WSTRB),
        .i_re    (w_ram_re),
        .i_raddr (r_r_addr[IW-1:0]),
        .o_rdata (w_ram_rdata)
    );

endmodule
